dist_sdpram_mrp: RTL and testbench
==================================

Name: dist_sdpram_mrp

Overview:
- Next-generation distributed (LUT) simple-dual-port RAM for the video/DDR FIFO path, single clock domain on wr_clk.
- Adds over the previous generation:
  - byte-enable writes
  - 1-4 independent read ports
  - selectable read latency 0/1/2 with rd_en/rd_valid handshake
  - write-first/read-first collision control
  - sequential clear engine that zeroes the whole array after reset or on request
- Used as the storage core of multi-reader line buffers and descriptor tables.

Parameters:
- ADDR_WIDTH, 4, address width, legal 4-10; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, word width, legal 8-256, must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8, bits per write-enable lane; NBE = DATA_WIDTH/BYTE_WIDTH.
- RD_PORTS, 2, number of read ports, legal 1-4.
- RD_LATENCY, 1, read latency in cycles, legal 0, 1, 2.
- BYPASS, 1, 1 = write-first on same-cycle address collision, 0 = read-first.
- CLEAR_ON_RST, 1, 1 = run clear engine after asyn_rst deasserts.

Ports:
- wr_clk  in  1  sole clock, rising edge.
- asyn_rst  in  1  reset, asynchronous, active-high.
- wr_en  in  1  write strobe.
- wr_be  in  NBE  byte-lane enables, lane k = wr_data[k*BYTE_WIDTH +: BYTE_WIDTH].
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- rd_en  in  RD_PORTS  per-port read request.
- rd_addr  in  RD_PORTS*ADDR_WIDTH  port p address at [p*ADDR_WIDTH +: ADDR_WIDTH].
- rd_data  out  RD_PORTS*DATA_WIDTH  port p data at [p*DATA_WIDTH +: DATA_WIDTH].
- rd_valid  out  RD_PORTS  port p data valid.
- clr_req  in  1  single-cycle soft clear request.
- init_busy  out  1  clear engine active.
- wr_drop  out  1  user write discarded this cycle.

Behaviour:
- Reset (asyn_rst high):
  - all rd_data registers 0, rd_valid 0, wr_drop 0.
  - FSM = CLEAR with counter 0 if CLEAR_ON_RST=1, otherwise IDLE.
  - init_busy = CLEAR_ON_RST.
  - Memory array is not reset directly.
- FSM IDLE:
  - User writes are accepted; reads are serviced.
  - clr_req=1 moves to CLEAR next edge, counter=0.
- FSM CLEAR:
  - Each edge writes 0 to mem[counter] and increments the counter.
  - After writing address 2**ADDR_WIDTH-1, returns to IDLE. Exactly 2**ADDR_WIDTH cycles with init_busy=1.
  - clr_req is ignored while in CLEAR.
  - asyn_rst mid-clear restarts the clear from address 0 (if CLEAR_ON_RST=1) or aborts to IDLE.
- User write (IDLE, wr_en=1):
  - On the edge, for each lane k with wr_be[k]=1, mem[wr_addr] lane k <= wr_data lane k; other lanes keep their value.
  - wr_be=0 with wr_en=1 leaves the word unchanged and is not a drop.
- wr_drop: registered, 1 for one cycle after any edge where wr_en=1 while in CLEAR; 0 otherwise.
- Read acceptance: rd_en[p] is accepted only in IDLE; in CLEAR, rd_en is ignored and rd_valid stays 0.
- RD_LATENCY=0:
  - rd_data[p] = mem[rd_addr[p]] combinationally.
  - rd_valid[p] = rd_en[p] & ~init_busy.
  - Same-cycle write is not visible until after the edge, regardless of BYPASS.
- RD_LATENCY=1:
  - Stage-1 register loads on accepted rd_en[p]; rd_valid[p] is 1 the following cycle.
  - rd_data holds its last value when no read is accepted.
- RD_LATENCY=2:
  - Second register stage; valid and data are delayed together.
  - Stage 2 always shifts, so rd_valid is a pure 2-cycle-delayed copy of accepted rd_en.
- Collision (RD_LATENCY>=1, accepted write and read to the same address in the same cycle):
  - BYPASS=1: stage 1 captures the merged word (new lanes where wr_be=1, old lanes otherwise).
  - BYPASS=0: stage 1 captures the old word.
- Multiple read ports may hit the same address simultaneously with no restriction.
- All read ports are independent and identical.

Decomposition:
- Package dist_sdpram_pkg:
  - clear-FSM state enum (ST_IDLE, ST_CLEAR)
  - parameter legality check constants (min/max ADDR_WIDTH, RD_PORTS)
  - function merging a word with byte enables
- Sub-module dist_sdpram_rd_pipe, one instance per port via generate: collision mux, latency stages, valid pipeline.
- Top level holds the array, write logic and the clear engine.

Test Plan:
- Post-reset clear, ADDR_WIDTH=4, CLEAR_ON_RST=1: release reset -> init_busy high exactly 16 cycles; afterwards a read of every address returns 0 with rd_valid 1 cycle after rd_en.
- Byte-enable write: write 0xAABBCCDD to addr 3, then 0x11223344 with wr_be=4'b0101 -> a read of addr 3 returns 0xAA22CC44.
- Collision, RD_LATENCY=1: addr 5 holds 0x0; in one cycle write 0xFFFF0000 (wr_be=1111) and read addr 5 on port 0 -> BYPASS=1 returns 0xFFFF0000, BYPASS=0 returns 0x0; a next-cycle reread returns 0xFFFF0000 in both cases.
- Multi-port, RD_LATENCY=2: port 0 reads addr 1 and port 1 reads addr 2 in the same cycle, with stored 0x1111 and 0x2222 -> both rd_valid rise exactly 2 cycles later with the correct words; the flattened bus slices are correct.
- Soft clear with writes: pulse clr_req, then wr_en=1 on the next 3 cycles -> wr_drop=1 for 3 cycles, memory is all-zero after init_busy falls, reads issued during CLEAR produce no rd_valid.
- Reset mid-clear: assert asyn_rst at clear address 7 -> rd_valid and rd_data go 0 immediately; after release the clear restarts at 0 and runs the full 16 cycles.

Source files
------------

// File: rtl/dist_sdpram_pkg.sv
// Shared types, parameter limits and the byte-lane merge used by the
// write path and the read-side collision bypass.
package dist_sdpram_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

    localparam int MIN_ADDR_WIDTH = 4;
    localparam int MAX_ADDR_WIDTH = 10;
    localparam int MIN_RD_PORTS   = 1;
    localparam int MAX_RD_PORTS   = 4;
    localparam int MIN_DATA_WIDTH = 8;
    localparam int MAX_DATA_WIDTH = 256;

    // Callers zero-extend to MAX_DATA_WIDTH and truncate the result back.
    function automatic logic [MAX_DATA_WIDTH-1:0] be_merge(
        input logic [MAX_DATA_WIDTH-1:0] old_word,
        input logic [MAX_DATA_WIDTH-1:0] new_word,
        input logic [MAX_DATA_WIDTH-1:0] be,
        input int                        byte_width
    );
        logic [MAX_DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MAX_DATA_WIDTH; i++) begin
            if (be[8'(i / byte_width)]) begin
                merged[8'(i)] = new_word[8'(i)];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/dist_sdpram_rd_pipe.sv
// One read port: collision mux, 0/1/2-stage data pipeline and matching
// valid pipeline.
module dist_sdpram_rd_pipe
    import dist_sdpram_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int RD_LATENCY = 1,
    parameter int BYPASS     = 1
) (
    input  logic                             wr_clk,
    input  logic                             asyn_rst,
    input  logic                             rd_accept,
    input  logic [ADDR_WIDTH-1:0]            rd_addr,
    input  logic [DATA_WIDTH-1:0]            mem_word,
    input  logic                             wr_accept,
    input  logic [ADDR_WIDTH-1:0]            wr_addr,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             rd_valid
);

    logic                  hit;
    logic [DATA_WIDTH-1:0] merged_word;
    logic [DATA_WIDTH-1:0] capture_word;

    assign hit          = wr_accept && (wr_addr == rd_addr);
    assign merged_word  = DATA_WIDTH'(be_merge(MAX_DATA_WIDTH'(mem_word),
                                               MAX_DATA_WIDTH'(wr_data),
                                               MAX_DATA_WIDTH'(wr_be),
                                               BYTE_WIDTH));
    // Write-first hands the post-edge word to stage 1; read-first keeps the array value.
    assign capture_word = ((BYPASS != 0) && hit) ? merged_word : mem_word;

    generate
        if (RD_LATENCY == 0) begin : g_lat0
            logic unused_sink;
            assign unused_sink = &{1'b0, wr_clk, asyn_rst, capture_word};
            assign rd_data     = mem_word;
            assign rd_valid    = rd_accept;
        end else begin : g_lat_reg
            logic [DATA_WIDTH-1:0] s1_data_reg;
            logic                  s1_valid_reg;

            always_ff @(posedge wr_clk or posedge asyn_rst) begin
                if (asyn_rst) begin
                    s1_data_reg  <= '0;
                    s1_valid_reg <= 1'b0;
                end else begin
                    s1_valid_reg <= rd_accept;
                    if (rd_accept) begin
                        s1_data_reg <= capture_word;
                    end
                end
            end

            if (RD_LATENCY == 1) begin : g_lat1
                assign rd_data  = s1_data_reg;
                assign rd_valid = s1_valid_reg;
            end else begin : g_lat2
                logic [DATA_WIDTH-1:0] s2_data_reg;
                logic                  s2_valid_reg;

                always_ff @(posedge wr_clk or posedge asyn_rst) begin
                    if (asyn_rst) begin
                        s2_data_reg  <= '0;
                        s2_valid_reg <= 1'b0;
                    end else begin
                        s2_data_reg  <= s1_data_reg;
                        s2_valid_reg <= s1_valid_reg;
                    end
                end

                assign rd_data  = s2_data_reg;
                assign rd_valid = s2_valid_reg;
            end
        end
    endgenerate

endmodule

// File: rtl/dist_sdpram_mrp.sv
// Distributed simple-dual-port RAM with byte enables, up to four read
// ports and a sequential clear engine.
module dist_sdpram_mrp
    import dist_sdpram_pkg::*;
#(
    parameter int ADDR_WIDTH   = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int BYTE_WIDTH   = 8,
    parameter int RD_PORTS     = 2,
    parameter int RD_LATENCY   = 1,
    parameter int BYPASS       = 1,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic                             wr_clk,
    input  logic                             asyn_rst,
    input  logic                             wr_en,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
    input  logic [ADDR_WIDTH-1:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic [RD_PORTS-1:0]              rd_en,
    input  logic [RD_PORTS*ADDR_WIDTH-1:0]   rd_addr,
    output logic [RD_PORTS*DATA_WIDTH-1:0]   rd_data,
    output logic [RD_PORTS-1:0]              rd_valid,
    input  logic                             clr_req,
    output logic                             init_busy,
    output logic                             wr_drop
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam clr_state_t RST_STATE = (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;

    generate
        if (ADDR_WIDTH < MIN_ADDR_WIDTH || ADDR_WIDTH > MAX_ADDR_WIDTH ||
            RD_PORTS < MIN_RD_PORTS || RD_PORTS > MAX_RD_PORTS ||
            DATA_WIDTH < MIN_DATA_WIDTH || DATA_WIDTH > MAX_DATA_WIDTH ||
            BYTE_WIDTH < 1 || (DATA_WIDTH % BYTE_WIDTH) != 0 ||
            RD_LATENCY < 0 || RD_LATENCY > 2) begin : g_param_error
            $error("dist_sdpram_mrp: illegal parameter combination");
        end
    endgenerate

    clr_state_t            state_reg, state_next;
    logic [ADDR_WIDTH-1:0] cnt_reg, cnt_next;
    logic                  wr_drop_reg;
    logic                  clearing;
    logic                  wr_accept;
    logic [RD_PORTS-1:0]   rd_accept;
    logic [DATA_WIDTH-1:0] wr_word;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign clearing  = (state_reg == ST_CLEAR);
    assign wr_accept = wr_en && !clearing;
    assign rd_accept = rd_en & {RD_PORTS{!clearing}};
    assign init_busy = clearing;
    assign wr_drop   = wr_drop_reg;

    always_ff @(posedge wr_clk or posedge asyn_rst) begin
        if (asyn_rst) begin
            state_reg   <= RST_STATE;
            cnt_reg     <= '0;
            wr_drop_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            wr_drop_reg <= wr_en && clearing;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (clr_req) begin
                    state_next = ST_CLEAR;
                    cnt_next   = '0;
                end
            end
            ST_CLEAR: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == '1) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Read-modify-write keeps unselected lanes; clearing owns the array outright.
    assign wr_word = DATA_WIDTH'(be_merge(MAX_DATA_WIDTH'(mem[wr_addr]),
                                          MAX_DATA_WIDTH'(wr_data),
                                          MAX_DATA_WIDTH'(wr_be),
                                          BYTE_WIDTH));

    always_ff @(posedge wr_clk) begin
        if (clearing) begin
            mem[cnt_reg] <= '0;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_word;
        end
    end

    generate
        for (genvar gi = 0; gi < RD_PORTS; gi++) begin : g_rd_port
            logic [ADDR_WIDTH-1:0] port_addr;
            logic [DATA_WIDTH-1:0] port_word;

            assign port_addr = rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign port_word = mem[port_addr];

            dist_sdpram_rd_pipe #(
                .ADDR_WIDTH (ADDR_WIDTH),
                .DATA_WIDTH (DATA_WIDTH),
                .BYTE_WIDTH (BYTE_WIDTH),
                .RD_LATENCY (RD_LATENCY),
                .BYPASS     (BYPASS)
            ) u_rd_pipe (
                .wr_clk    (wr_clk),
                .asyn_rst  (asyn_rst),
                .rd_accept (rd_accept[gi]),
                .rd_addr   (port_addr),
                .mem_word  (port_word),
                .wr_accept (wr_accept),
                .wr_addr   (wr_addr),
                .wr_be     (wr_be),
                .wr_data   (wr_data),
                .rd_data   (rd_data[gi*DATA_WIDTH +: DATA_WIDTH]),
                .rd_valid  (rd_valid[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_dist_sdpram_mrp.sv
// Directed bench: four RAM variants (latency 0, latency 1 write-first,
// latency 1 read-first, latency 2) share one stimulus stream.
module tb_dist_sdpram_mrp;

    logic        clk = 1'b0;
    logic        asyn_rst;
    logic        wr_en;
    logic [3:0]  wr_be;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic [1:0]  rd_en;
    logic [7:0]  rd_addr;
    logic        clr_req;

    logic [63:0] l0_data, l1_data, rf_data, l2_data;
    logic [1:0]  l0_valid, l1_valid, rf_valid, l2_valid;
    logic        l0_busy, l1_busy, rf_busy, l2_busy;
    logic        l0_drop, l1_drop, rf_drop, l2_drop;

    int n_total = 0;
    int n_pass  = 0;
    int n;

    always #5 clk = ~clk;

    dist_sdpram_mrp #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8), .RD_PORTS(2),
                      .RD_LATENCY(0), .BYPASS(1), .CLEAR_ON_RST(1)) u_l0 (
        .wr_clk(clk), .asyn_rst(asyn_rst), .wr_en(wr_en), .wr_be(wr_be),
        .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(l0_data), .rd_valid(l0_valid), .clr_req(clr_req),
        .init_busy(l0_busy), .wr_drop(l0_drop));

    dist_sdpram_mrp #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8), .RD_PORTS(2),
                      .RD_LATENCY(1), .BYPASS(1), .CLEAR_ON_RST(1)) u_l1 (
        .wr_clk(clk), .asyn_rst(asyn_rst), .wr_en(wr_en), .wr_be(wr_be),
        .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(l1_data), .rd_valid(l1_valid), .clr_req(clr_req),
        .init_busy(l1_busy), .wr_drop(l1_drop));

    dist_sdpram_mrp #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8), .RD_PORTS(2),
                      .RD_LATENCY(1), .BYPASS(0), .CLEAR_ON_RST(1)) u_rf (
        .wr_clk(clk), .asyn_rst(asyn_rst), .wr_en(wr_en), .wr_be(wr_be),
        .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rf_data), .rd_valid(rf_valid), .clr_req(clr_req),
        .init_busy(rf_busy), .wr_drop(rf_drop));

    dist_sdpram_mrp #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8), .RD_PORTS(2),
                      .RD_LATENCY(2), .BYPASS(1), .CLEAR_ON_RST(1)) u_l2 (
        .wr_clk(clk), .asyn_rst(asyn_rst), .wr_en(wr_en), .wr_be(wr_be),
        .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(l2_data), .rd_valid(l2_valid), .clr_req(clr_req),
        .init_busy(l2_busy), .wr_drop(l2_drop));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
            $display("check %s: observed=%h", tag, obs);
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        asyn_rst = 1'b1;
        wr_en    = 1'b0;
        wr_be    = 4'h0;
        wr_addr  = 4'h0;
        wr_data  = 32'h0;
        rd_en    = 2'b00;
        rd_addr  = 8'h00;
        clr_req  = 1'b0;
        repeat (2) tick();

        // Reset state
        check("rst_busy",   64'(l1_busy),  64'd1);
        check("rst_valid",  64'(l1_valid), 64'd0);
        check("rst_data1",  l1_data,       64'd0);
        check("rst_data2",  l2_data,       64'd0);
        check("rst_drop",   64'(l1_drop),  64'd0);

        // Post-reset clear length
        asyn_rst = 1'b0;
        n = 0;
        while (l1_busy && n < 40) begin
            tick();
            n++;
        end
        check("clr_len", 64'(n), 64'd16);
        check("clr_len_l2", 64'(l2_busy), 64'd0);

        // Every address reads zero, valid one cycle after rd_en
        for (int a = 0; a < 16; a += 2) begin
            rd_en   = 2'b11;
            rd_addr = {4'(a + 1), 4'(a)};
            if (a == 0) check("valid_pre", 64'(l1_valid), 64'd0);
            tick();
            check("zero_valid", 64'(l1_valid), 64'd3);
            check("zero_data",  l1_data,       64'd0);
        end
        rd_en = 2'b00;
        tick();
        check("valid_drop", 64'(l1_valid), 64'd0);

        // Byte-enable write
        wr_en = 1'b1; wr_be = 4'hF; wr_addr = 4'd3; wr_data = 32'hAABBCCDD;
        tick();
        wr_be = 4'b0101; wr_data = 32'h11223344;
        tick();
        wr_be = 4'b0000; wr_data = 32'h0;
        tick();
        check("be0_nodrop", 64'(l1_drop), 64'd0);
        wr_en = 1'b0;
        rd_en = 2'b01; rd_addr = {4'd0, 4'd3};
        #1;
        check("be_l0_data",  64'(l0_data[31:0]), 64'hAA22CC44);
        check("be_l0_valid", 64'(l0_valid),      64'd1);
        tick();
        check("be_l1_data",  64'(l1_data[31:0]), 64'hAA22CC44);
        check("be_l1_valid", 64'(l1_valid),      64'd1);
        rd_en = 2'b00;
        tick();
        check("be_l2_data",  64'(l2_data[31:0]), 64'hAA22CC44);
        check("be_l2_valid", 64'(l2_valid),      64'd1);
        check("be_l1_idle",  64'(l1_valid),      64'd0);

        // Collision on address 5 (holds zero)
        wr_en = 1'b1; wr_be = 4'hF; wr_addr = 4'd5; wr_data = 32'hFFFF0000;
        rd_en = 2'b01; rd_addr = {4'd0, 4'd5};
        #1;
        check("col_l0_old", 64'(l0_data[31:0]), 64'h0);
        tick();
        check("col_wf", 64'(l1_data[31:0]), 64'hFFFF0000);
        check("col_rf", 64'(rf_data[31:0]), 64'h0);
        // Partial-lane collision on port 0, plain read on port 1
        wr_be = 4'b0011; wr_addr = 4'd6; wr_data = 32'h12345678;
        rd_en = 2'b11; rd_addr = {4'd5, 4'd6};
        tick();
        check("colp_wf", l1_data, 64'hFFFF0000_00005678);
        check("colp_rf", rf_data, 64'hFFFF0000_00000000);
        wr_en = 1'b0;
        rd_addr = {4'd6, 4'd5};
        tick();
        check("reread_wf", l1_data, 64'h00005678_FFFF0000);
        check("reread_rf", rf_data, 64'h00005678_FFFF0000);
        rd_en = 2'b00;
        tick();

        // Multi-port, two-cycle latency
        wr_en = 1'b1; wr_be = 4'hF; wr_addr = 4'd1; wr_data = 32'h00001111;
        tick();
        wr_addr = 4'd2; wr_data = 32'h00002222;
        tick();
        wr_en = 1'b0;
        rd_en = 2'b11; rd_addr = {4'd2, 4'd1};
        tick();
        rd_en = 2'b00;
        check("mp_valid_1cyc", 64'(l2_valid), 64'd0);
        tick();
        check("mp_valid_2cyc", 64'(l2_valid),        64'd3);
        check("mp_port0",      64'(l2_data[31:0]),   64'h00001111);
        check("mp_port1",      64'(l2_data[63:32]),  64'h00002222);
        tick();
        check("mp_valid_3cyc", 64'(l2_valid), 64'd0);

        // Soft clear with dropped writes and ignored reads
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        check("sc_busy", 64'(l1_busy), 64'd1);
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_be = 4'hF; wr_addr = 4'd0; wr_data = 32'hDEADBEEF;
            rd_en = 2'b11; rd_addr = {4'd2, 4'd1};
            #1;
            check("sc_l0_novalid", 64'(l0_valid), 64'd0);
            tick();
            check("sc_drop",    64'(l1_drop),  64'd1);
            check("sc_novalid", 64'(l1_valid), 64'd0);
        end
        wr_en = 1'b0; rd_en = 2'b00;
        tick();
        check("sc_drop_end", 64'(l1_drop), 64'd0);
        n = 0;
        while (l1_busy && n < 40) begin
            tick();
            n++;
        end
        check("sc_done", 64'(l1_busy), 64'd0);
        for (int a = 0; a < 16; a += 2) begin
            rd_en   = 2'b11;
            rd_addr = {4'(a + 1), 4'(a)};
            tick();
            check("sc_zero", l1_data, 64'd0);
        end
        rd_en = 2'b00;
        tick();

        // Reset in the middle of a clear
        wr_en = 1'b1; wr_be = 4'hF; wr_addr = 4'd9; wr_data = 32'hCAFEF00D;
        tick();
        wr_en = 1'b0;
        rd_en = 2'b01; rd_addr = {4'd0, 4'd9};
        tick();
        check("rm_pre_data",  64'(l1_data[31:0]), 64'hCAFEF00D);
        check("rm_pre_valid", 64'(l1_valid),      64'd1);
        rd_en = 2'b00; clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (7) tick();
        check("rm_hold",    64'(l1_data[31:0]), 64'hCAFEF00D);
        check("rm_busy7",   64'(l1_busy),       64'd1);
        asyn_rst = 1'b1;
        #1;
        check("rm_data1",  l1_data,       64'd0);
        check("rm_data2",  l2_data,       64'd0);
        check("rm_valid",  64'(l1_valid), 64'd0);
        tick();
        asyn_rst = 1'b0;
        n = 0;
        while (l1_busy && n < 40) begin
            tick();
            n++;
        end
        check("rm_clr_len", 64'(n), 64'd16);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
